// File: rtl/divisor_sequencial.sv
// rtl/divisor_sequencial.sv - sequential restoring unsigned divider, one quotient bit per clock
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   start      request a division (sampled only while idle)
//   dividendo  unsigned dividend, captured on accepted start
//   divisor    unsigned divisor, captured on accepted start
//   quociente  registered quotient
//   resto      registered remainder
//   ocupado    high while a division is calculating or completing
//   pronto     one-cycle pulse when quociente/resto are valid
//   erro_div0  registered flag: last accepted divisor was zero
module divisor_sequencial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividendo,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quociente,
    output logic [N-1:0] resto,
    output logic         ocupado,
    output logic         pronto,
    output logic         erro_div0
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_n;
    logic [N-1:0]   dvd, dvd_n;          // dividend, shifted out MSB-first
    logic [N-1:0]   dvs, dvs_n;
    logic [N:0]     partial, partial_n;  // partial remainder
    logic [N-1:0]   qt, qt_n;            // quotient being assembled
    logic [CW-1:0]  cnt, cnt_n;
    logic [N-1:0]   quociente_n, resto_n;
    logic           ocupado_n, pronto_n, erro_div0_n;

    // One extra top bit so the subtraction's MSB is the borrow out.
    logic [N+1:0]   shifted, diff;
    logic           qbit;
    logic [N:0]     step_partial;
    logic [N-1:0]   step_qt;

    always_comb begin
        shifted      = {partial, dvd[N-1]};
        diff         = shifted - {2'b00, dvs};
        qbit         = ~diff[N+1];
        step_partial = qbit ? diff[N:0] : shifted[N:0];
        step_qt      = {qt[N-2:0], qbit};
    end

    always_comb begin
        state_n     = state;
        dvd_n       = dvd;
        dvs_n       = dvs;
        partial_n   = partial;
        qt_n        = qt;
        cnt_n       = cnt;
        quociente_n = quociente;
        resto_n     = resto;
        ocupado_n   = ocupado;
        pronto_n    = 1'b0;
        erro_div0_n = erro_div0;

        case (state)
            IDLE: begin
                if (start) begin
                    dvd_n       = dividendo;
                    dvs_n       = divisor;
                    partial_n   = '0;
                    qt_n        = '0;
                    cnt_n       = '0;
                    erro_div0_n = 1'b0;
                    ocupado_n   = 1'b1;
                    state_n     = CALC;
                end
            end
            CALC: begin
                if (dvs == '0) begin
                    // Divide by zero: skip iterations, report saturated quotient.
                    quociente_n = '1;
                    resto_n     = dvd;
                    erro_div0_n = 1'b1;
                    pronto_n    = 1'b1;
                    state_n     = DONE;
                end else begin
                    dvd_n     = {dvd[N-2:0], 1'b0};
                    partial_n = step_partial;
                    qt_n      = step_qt;
                    cnt_n     = cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        quociente_n = step_qt;
                        resto_n     = step_partial[N-1:0];
                        pronto_n    = 1'b1;
                        state_n     = DONE;
                    end
                end
            end
            DONE: begin
                ocupado_n = 1'b0;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dvd       <= '0;
            dvs       <= '0;
            partial   <= '0;
            qt        <= '0;
            cnt       <= '0;
            quociente <= '0;
            resto     <= '0;
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
            erro_div0 <= 1'b0;
        end else begin
            state     <= state_n;
            dvd       <= dvd_n;
            dvs       <= dvs_n;
            partial   <= partial_n;
            qt        <= qt_n;
            cnt       <= cnt_n;
            quociente <= quociente_n;
            resto     <= resto_n;
            ocupado   <= ocupado_n;
            pronto    <= pronto_n;
            erro_div0 <= erro_div0_n;
        end
    end

endmodule

// File: tb/tb_divisor_sequencial.sv
// tb/tb_divisor_sequencial.sv - scoreboard bench for divisor_sequencial
module tb_divisor_sequencial;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] dividendo = '0;
    logic [N-1:0] divisor = '0;
    logic [N-1:0] quociente, resto;
    logic         ocupado, pronto, erro_div0;

    divisor_sequencial #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividendo(dividendo),
        .divisor(divisor),
        .quociente(quociente),
        .resto(resto),
        .ocupado(ocupado),
        .pronto(pronto),
        .erro_div0(erro_div0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         e;
        int           at;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pronto pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (pronto) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pronto actual 1 expected 0 (cycle %0d)", cyc);
            end else begin
                cur = sb.pop_front();
                chk("quociente", 32'(quociente), 32'(cur.q));
                chk("resto", 32'(resto), 32'(cur.r));
                chk("erro_div0", 32'(erro_div0), 32'(cur.e));
                chk("latency_edge", 32'(cyc), 32'(cur.at));
            end
        end
    end

    // Issue one request; if push, the expected response goes to the scoreboard.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] q, input logic [N-1:0] r,
                         input logic e, input bit push);
        int t;
        @(negedge clk);
        dividendo = a;
        divisor   = b;
        start     = 1'b1;
        t = cyc + 1;
        if (push) sb.push_back('{q: q, r: r, e: e, at: (b == 0) ? t + 1 : t + N});
        @(negedge clk);
        start     = 1'b0;
        dividendo = N'($urandom);
        divisor   = N'($urandom);
        chk("ocupado_busy", 32'(ocupado), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout actual pending=%0d expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_quociente"}, 32'(quociente), 32'd0);
        chk({tag, "_resto"}, 32'(resto), 32'd0);
        chk({tag, "_ocupado"}, 32'(ocupado), 32'd0);
        chk({tag, "_pronto"}, 32'(pronto), 32'd0);
        chk({tag, "_erro_div0"}, 32'(erro_div0), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] a, b;
        logic [N-1:0] ca[7];
        logic [N-1:0] cb[7];

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Directed vectors
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1);
        wait_done();
        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1);
        wait_done();
        issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b1);
        wait_done();
        issue(8'd42, 8'd0, 8'd255, 8'd42, 1'b1, 1'b1);
        wait_done();
        chk("div0_flag_held", 32'(erro_div0), 32'd1);
        issue(8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 1'b1);
        wait_done();

        // Start during CALC is dropped
        issue(8'd200, 8'd10, 8'd20, 8'd0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        dividendo = 8'd9;
        divisor   = 8'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (12) @(negedge clk);
        chk("idle_ocupado", 32'(ocupado), 32'd0);
        chk("idle_hold_quociente", 32'(quociente), 32'd20);
        chk("idle_hold_resto", 32'(resto), 32'd0);

        // Reset mid-CALC aborts without pronto
        issue(8'd100, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        rst = 1'b0;
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1);
        wait_done();

        // Sweep with corners first
        ca = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd1, 8'd255};
        cb = '{8'd0, 8'd1, 8'd255, 8'd0, 8'd255, 8'd255, 8'd254};
        for (int i = 0; i < 1000; i++) begin
            if (i < 7) begin
                a = ca[i];
                b = cb[i];
            end else begin
                a = N'($urandom_range(0, 255));
                b = N'($urandom_range(0, 255));
            end
            if (b == 0) issue(a, b, 8'd255, a, 1'b1, 1'b1);
            else        issue(a, b, a / b, a % b, 1'b0, 1'b1);
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divisor_sequencial.md
DIVISOR_SEQUENCIAL -- requirements
Module: divisor_sequencial

Interface
REQ-001 SHALL have parameter: N, 8, operand/result width in bits (N >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port: dividendo  input  N  unsigned dividend, captured on accepted start.
REQ-006 SHALL have port: divisor  input  N  unsigned divisor, captured on accepted start.
REQ-007 SHALL have port: quociente  output  N  unsigned quotient, registered.
REQ-008 SHALL have port: resto  output  N  unsigned remainder, registered.
REQ-009 SHALL have port: ocupado  output  1  high while in CALC or DONE.
REQ-010 SHALL have port: pronto  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have port: erro_div0  output  1  registered flag; last accepted divisor was zero.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; every output registered.
REQ-013 IDLE + start=1 SHALL capture both operands, clear the internal partial remainder (N+1 bits) and the bit counter, and go to CALC; the same edge SHALL clear erro_div0.
REQ-014 IDLE + start=0 SHALL hold state and all outputs.
REQ-015 Captured divisor=0 SHALL go CALC->DONE on the first CALC cycle with quociente=all ones, resto=captured dividendo, erro_div0=1, and no iterations.
REQ-016 Each CALC cycle SHALL perform one restoring step, taking dividend bits MSB-first:
- shift partial remainder left by one, inserting the next dividend bit;
- compute trial = partial - divisor (N+1 bits, ripple borrow);
- no borrow: partial=trial, quotient bit=1;
- borrow: partial unchanged, quotient bit=0.
REQ-017 After exactly N CALC cycles, the FSM SHALL go to DONE and SHALL load quociente and resto (low N bits of partial) on that same edge.
REQ-018 Latency: start accepted at edge t -> pronto=1 during the cycle after edge t+N (nonzero divisor), or after edge t+1 (zero divisor).
REQ-019 DONE SHALL last exactly one cycle with pronto=1, then go to IDLE; pronto=0 in every other state.
REQ-020 start during CALC or DONE SHALL be ignored, with no effect on operands, counter or results.
REQ-021 quociente, resto and erro_div0 SHALL hold their values from DONE until the next division completes; inputs changing after capture SHALL not affect the running division.
REQ-022 Results SHALL satisfy dividendo = quociente*divisor + resto and resto < divisor, for every nonzero divisor.
REQ-023 Bit counter SHALL be ceil(log2(N+1)) bits wide and SHALL not wrap during a division.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and quociente=0, resto=0, ocupado=0, pronto=0, erro_div0=0, internal registers 0, overriding start in any state.
REQ-025 rst asserted mid-CALC SHALL abort the division with no pronto pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-026 N=8, dividendo=100, divisor=7, start one cycle -> pronto after 9 edges, quociente=14, resto=2, erro_div0=0.
REQ-027 dividendo=255, divisor=1 -> quociente=255, resto=0; dividendo=5, divisor=9 -> quociente=0, resto=5.
REQ-028 divisor=0, dividendo=42 -> pronto after 2 edges, quociente=255, resto=42, erro_div0=1; next 10/3 -> q=3, r=1, erro_div0=0.
REQ-029 start 200/10, then start=1 with 9/3 on CALC cycle 3 -> result q=20, r=0; exactly one pronto pulse; second request dropped.
REQ-030 rst on CALC cycle 4 of 100/7 -> all outputs 0, no pronto; then 100/7 -> q=14, r=2 with normal latency.
REQ-031 Random sweep of 1000 operand pairs, N=8, including 0 and 255 corners -> REQ-022 holds, latency per REQ-018.
